vector_exe_stage: RTL and testbench
===================================

// Module: vector_exe_stage
// PURPOSE
//  Execute stage of the vector pipeline. Consumes the ID/EXE register outputs and computes lane-wise ops over LANES x LANE_W packed vectors.
//  Registers the result, store data and MEM/WB control toward the EXE/MEM register.
//  Multiply ops run serially, one lane per cycle; stall_out freezes the upstream stages meanwhile.
// PARAMETERS
//  LANES   4  number of vector lanes
//  LANE_W  8  bits per lane; vector width VW = LANES*LANE_W (32)
// PORTS
//  clk            in   1    pipeline clock, all state on posedge
//  rst            in   1    asynchronous, active-high reset
//  valid_in       in   1    ID/EXE holds a real instruction
//  opcode_in      in   4    ALU opcode (map below)
//  sel_op_in      in   1    operand A: 0=VEC1_in, 1=VFS_in
//  sel_vec_in     in   2    operand B: 00=VEC2_in, 01=sca1_in bcast, 10=inmediato_in bcast, 11=VFS_in
//  sel_int_in     in   1    passed through to sel_int_out
//  VEC1_in/VEC2_in/VFS_in  in  VW  vector operands
//  sca1_in, inmediato_in, shift_in  in  LANE_W  scalar, immediate, shift amount
//  dir_dest_in    in   3    destination register address
//  ctrl_mem_in    in   5    {sel_pcmem,sum_mem,sel_mem,sel_data,mem_wr}
//  ctrl_wb_in     in   3    {sel_wb,reg_wrv,reg_wrs}
//  result_out     out  VW   ALU result
//  store_out      out  VW   VEC2_in captured with the instruction (store data)
//  dir_dest_out, ctrl_mem_out, ctrl_wb_out, sel_int_out  out  3/5/3/1  registered pass-through
//  valid_out      out  1    outputs carry a completed instruction this cycle
//  stall_out      out  1    upstream must hold its outputs (combinational from state)
// BEHAVIOUR
//  Reset: every output 0, FSM=IDLE, lane counter 0; takes effect immediately, asynchronously.
//  Opcodes (all lane-wise, modulo 2^LANE_W unless stated):
//   0 ADD  1 SUB  2 AND  3 OR  4 XOR  5 SLL by shift_in  6 SRL by shift_in (amount >= LANE_W -> 0)
//   7 MUL low LANE_W bits (multi)  8 MAC = VFS_in + A*B (multi)  9 MOV B  10 ADDS unsigned saturating (0xFF)
//   11 MIN unsigned  12 MAX unsigned  13 RSUM: lane0 = sum of A lanes mod 2^LANE_W, other lanes 0  14,15 NOP: result=A
//  FSM IDLE/MUL:
//   IDLE, valid_in, single-cycle op -> registered next posedge, valid_out=1 for 1 cycle, latency 1.
//   IDLE, valid_in, op 7/8 -> MUL, capture A, B, VFS_in and pass-through fields; lane idx=0.
//     stall_out=1 from that cycle.
//   MUL: one lane product per cycle into the result accumulator; idx++.
//     After lane LANES-1 -> IDLE with valid_out=1; stall_out low in the final MUL cycle. Total latency LANES cycles.
//   Inputs are ignored while in MUL; the held ID/EXE values are not re-executed.
//   IDLE, valid_in=0 -> valid_out=0; result/pass-through outputs hold their last value.
//   ctrl_mem_out/ctrl_wb_out forced 0 whenever valid_out=0 (no spurious writes).
//  Reset mid-MUL aborts: partial result discarded, no valid_out.
//  Widths: products truncated to LANE_W. SUB wraps (0x00-0x01=0xFF). Carries never cross lanes.
// STRUCTURE
//  vexe_pkg: opcode localparams, sel_vec encodings, ctrl_mem/ctrl_wb bit indices, FSM state enum.
//  Sub-module vexe_lane_alu: combinational single-lane ALU (ops 0-6, 9-12), instantiated per lane via generate.
//  Top keeps operand muxes, serial multiplier, RSUM tree, FSM and output registers.
// TESTING
//  ADD A=0x01020304, B=VEC2 0x10FF0101 -> result 0x11010405, valid_out 1 cycle after.
//  SUB + sel_vec=10, inmediato=0x05, A=0x00050A03 -> 0xFB0005FE (per-lane wrap).
//  MUL A=0x02030405, B=sca1=0x03 -> stall_out high 3 cycles; result 0x06090C0F at cycle 4; upstream values not re-executed.
//  Reset asserted in cycle 2 of MUL -> outputs 0 at once; no valid_out; next ADD executes normally.
//  ADDS 0xF0F00101+0x20100101 -> 0xFFFF0202; SRL shift_in=8 -> 0x00000000.
//  Back-to-back ADD,RSUM(A=0x80808080),NOP -> valid_out 3 consecutive cycles; RSUM result 0x00000000; ctrl fields track each op.

Source files
------------

// File: rtl/vexe_pkg.sv
// Shared encodings for the vector execute stage: opcodes, operand-B selects,
// control-field bit positions and the multiply sequencer state.
package vexe_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_MUL  = 4'd7;
  localparam logic [3:0] OP_MAC  = 4'd8;
  localparam logic [3:0] OP_MOV  = 4'd9;
  localparam logic [3:0] OP_ADDS = 4'd10;
  localparam logic [3:0] OP_MIN  = 4'd11;
  localparam logic [3:0] OP_MAX  = 4'd12;
  localparam logic [3:0] OP_RSUM = 4'd13;
  localparam logic [3:0] OP_NOP  = 4'd14;

  localparam logic [1:0] SV_VEC2 = 2'b00;
  localparam logic [1:0] SV_SCA  = 2'b01;
  localparam logic [1:0] SV_IMM  = 2'b10;
  localparam logic [1:0] SV_VFS  = 2'b11;

  // ctrl_mem = {sel_pcmem, sum_mem, sel_mem, sel_data, mem_wr}
  localparam int CM_MEM_WR    = 0;
  localparam int CM_SEL_DATA  = 1;
  localparam int CM_SEL_MEM   = 2;
  localparam int CM_SUM_MEM   = 3;
  localparam int CM_SEL_PCMEM = 4;

  // ctrl_wb = {sel_wb, reg_wrv, reg_wrs}
  localparam int CW_REG_WRS = 0;
  localparam int CW_REG_WRV = 1;
  localparam int CW_SEL_WB  = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } vexe_state_e;

endpackage

// File: rtl/vexe_lane_alu.sv
// Combinational single-lane ALU for the single-cycle opcodes. Multiply and
// reduction opcodes are handled in the stage top; here they fall through to A.
module vexe_lane_alu
  import vexe_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [3:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] shamt,
  output logic [W-1:0] y
);

  localparam logic [W-1:0] W_L = W[W-1:0];

  logic [W:0] sum_ext;

  assign sum_ext = {1'b0, a} + {1'b0, b};

  always_comb begin
    y = a;
    case (op)
      OP_ADD:  y = sum_ext[W-1:0];
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_SLL:  y = (shamt >= W_L) ? '0 : (a << shamt);
      OP_SRL:  y = (shamt >= W_L) ? '0 : (a >> shamt);
      OP_MOV:  y = b;
      OP_ADDS: y = sum_ext[W] ? '1 : sum_ext[W-1:0];
      OP_MIN:  y = (a < b) ? a : b;
      OP_MAX:  y = (a > b) ? a : b;
      default: y = a;
    endcase
  end

endmodule

// File: rtl/vector_exe_stage.sv
// Vector pipeline execute stage: lane-wise ALU, serial one-lane-per-cycle
// multiplier with upstream stall, and the EXE/MEM output register.
module vector_exe_stage
  import vexe_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int LANE_W = 8,
  localparam int VW    = LANES * LANE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic [3:0]        opcode_in,
  input  logic              sel_op_in,
  input  logic [1:0]        sel_vec_in,
  input  logic              sel_int_in,
  input  logic [VW-1:0]     VEC1_in,
  input  logic [VW-1:0]     VEC2_in,
  input  logic [VW-1:0]     VFS_in,
  input  logic [LANE_W-1:0] sca1_in,
  input  logic [LANE_W-1:0] inmediato_in,
  input  logic [LANE_W-1:0] shift_in,
  input  logic [2:0]        dir_dest_in,
  input  logic [4:0]        ctrl_mem_in,
  input  logic [2:0]        ctrl_wb_in,
  output logic [VW-1:0]     result_out,
  output logic [VW-1:0]     store_out,
  output logic [2:0]        dir_dest_out,
  output logic [4:0]        ctrl_mem_out,
  output logic [2:0]        ctrl_wb_out,
  output logic              sel_int_out,
  output logic              valid_out,
  output logic              stall_out,
  output vexe_state_e       dbg_state
);

  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

  // Handshake: there is no ready input. valid_in marks a live ID/EXE entry;
  // while stall_out=1 upstream must hold it, and valid_out pulses exactly
  // once per completed instruction with ctrl fields zero otherwise.

  vexe_state_e state, state_n;

  logic [VW-1:0]     op_a, op_b, alu_y, single_res;
  logic [LANE_W-1:0] rsum;
  logic              is_mul;

  logic [VW-1:0]     mul_a, mul_b, mul_c, mul_acc, acc_next;
  logic              mul_mac;
  logic [IDX_W-1:0]  idx;
  logic              last_lane;
  logic [LANE_W-1:0] cur_a, cur_b, cur_c, lane_prod, lane_val;

  logic [VW-1:0]     hold_store;
  logic [2:0]        hold_dir;
  logic [4:0]        hold_mem;
  logic [2:0]        hold_wb;
  logic              hold_sel_int;

  assign op_a = sel_op_in ? VFS_in : VEC1_in;

  always_comb begin
    op_b = VEC2_in;
    case (sel_vec_in)
      SV_VEC2: op_b = VEC2_in;
      SV_SCA:  op_b = {LANES{sca1_in}};
      SV_IMM:  op_b = {LANES{inmediato_in}};
      SV_VFS:  op_b = VFS_in;
      default: op_b = VEC2_in;
    endcase
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    vexe_lane_alu #(.W(LANE_W)) u_alu (
      .op    (opcode_in),
      .a     (op_a[g*LANE_W +: LANE_W]),
      .b     (op_b[g*LANE_W +: LANE_W]),
      .shamt (shift_in),
      .y     (alu_y[g*LANE_W +: LANE_W])
    );
  end

  always_comb begin
    rsum = '0;
    for (int i = 0; i < LANES; i++) rsum = rsum + op_a[i*LANE_W +: LANE_W];
  end

  assign single_res = (opcode_in == OP_RSUM) ? {{(VW-LANE_W){1'b0}}, rsum} : alu_y;
  assign is_mul     = (opcode_in == OP_MUL) || (opcode_in == OP_MAC);

  // Serial multiplier: lane idx of the captured operands, truncated to LANE_W.
  assign cur_a     = mul_a[idx*LANE_W +: LANE_W];
  assign cur_b     = mul_b[idx*LANE_W +: LANE_W];
  assign cur_c     = mul_c[idx*LANE_W +: LANE_W];
  assign lane_prod = cur_a * cur_b;
  assign lane_val  = lane_prod + (mul_mac ? cur_c : '0);
  assign last_lane = (idx == IDX_W'(LANES - 1));

  always_comb begin
    acc_next = mul_acc;
    acc_next[idx*LANE_W +: LANE_W] = lane_val;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (valid_in && is_mul) state_n = ST_MUL;
      ST_MUL:  if (last_lane) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  // The final MUL cycle leaves stall low so upstream advances as we retire.
  assign stall_out = (state == ST_MUL) && !last_lane;
  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_out   <= '0;
      store_out    <= '0;
      dir_dest_out <= '0;
      ctrl_mem_out <= '0;
      ctrl_wb_out  <= '0;
      sel_int_out  <= 1'b0;
      valid_out    <= 1'b0;
      mul_a        <= '0;
      mul_b        <= '0;
      mul_c        <= '0;
      mul_acc      <= '0;
      mul_mac      <= 1'b0;
      idx          <= '0;
      hold_store   <= '0;
      hold_dir     <= '0;
      hold_mem     <= '0;
      hold_wb      <= '0;
      hold_sel_int <= 1'b0;
    end else begin
      valid_out    <= 1'b0;
      ctrl_mem_out <= '0;
      ctrl_wb_out  <= '0;
      case (state)
        ST_IDLE: begin
          if (valid_in && is_mul) begin
            mul_a        <= op_a;
            mul_b        <= op_b;
            mul_c        <= VFS_in;
            mul_mac      <= (opcode_in == OP_MAC);
            mul_acc      <= '0;
            idx          <= '0;
            hold_store   <= VEC2_in;
            hold_dir     <= dir_dest_in;
            hold_mem     <= ctrl_mem_in;
            hold_wb      <= ctrl_wb_in;
            hold_sel_int <= sel_int_in;
          end else if (valid_in) begin
            result_out   <= single_res;
            store_out    <= VEC2_in;
            dir_dest_out <= dir_dest_in;
            ctrl_mem_out <= ctrl_mem_in;
            ctrl_wb_out  <= ctrl_wb_in;
            sel_int_out  <= sel_int_in;
            valid_out    <= 1'b1;
          end
        end
        ST_MUL: begin
          mul_acc <= acc_next;
          idx     <= idx + 1'b1;
          if (last_lane) begin
            result_out   <= acc_next;
            store_out    <= hold_store;
            dir_dest_out <= hold_dir;
            ctrl_mem_out <= hold_mem;
            ctrl_wb_out  <= hold_wb;
            sel_int_out  <= hold_sel_int;
            valid_out    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_exe_stage.sv
// Directed bench for vector_exe_stage: hand-computed vectors, expected-result
// queue, single check task and one summary line.
module tb_vector_exe_stage;
  import vexe_pkg::*;

  localparam int W = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [3:0]  opcode_in;
  logic        sel_op_in;
  logic [1:0]  sel_vec_in;
  logic        sel_int_in;
  logic [31:0] VEC1_in, VEC2_in, VFS_in;
  logic [7:0]  sca1_in, inmediato_in, shift_in;
  logic [2:0]  dir_dest_in;
  logic [4:0]  ctrl_mem_in;
  logic [2:0]  ctrl_wb_in;
  logic [31:0] result_out, store_out;
  logic [2:0]  dir_dest_out;
  logic [4:0]  ctrl_mem_out;
  logic [2:0]  ctrl_wb_out;
  logic        sel_int_out, valid_out, stall_out;
  vexe_state_e dbg_state;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_res;
  int n_tests = 0;
  int n_fail  = 0;
  int lat, stall_cnt;

  localparam logic [4:0] CM_STORE = 5'(1 << CM_MEM_WR) | 5'(1 << CM_SEL_DATA);
  localparam logic [4:0] CM_LOAD  = 5'(1 << CM_SEL_MEM) | 5'(1 << CM_SUM_MEM);
  localparam logic [4:0] CM_PC    = 5'(1 << CM_SEL_PCMEM);
  localparam logic [2:0] CW_VEC   = 3'(1 << CW_REG_WRV);
  localparam logic [2:0] CW_SCA   = 3'(1 << CW_REG_WRS) | 3'(1 << CW_SEL_WB);

  vector_exe_stage #(.LANES(4), .LANE_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_in     (valid_in),
    .opcode_in    (opcode_in),
    .sel_op_in    (sel_op_in),
    .sel_vec_in   (sel_vec_in),
    .sel_int_in   (sel_int_in),
    .VEC1_in      (VEC1_in),
    .VEC2_in      (VEC2_in),
    .VFS_in       (VFS_in),
    .sca1_in      (sca1_in),
    .inmediato_in (inmediato_in),
    .shift_in     (shift_in),
    .dir_dest_in  (dir_dest_in),
    .ctrl_mem_in  (ctrl_mem_in),
    .ctrl_wb_in   (ctrl_wb_in),
    .result_out   (result_out),
    .store_out    (store_out),
    .dir_dest_out (dir_dest_out),
    .ctrl_mem_out (ctrl_mem_out),
    .ctrl_wb_out  (ctrl_wb_out),
    .sel_int_out  (sel_int_out),
    .valid_out    (valid_out),
    .stall_out    (stall_out),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic issue(input logic [3:0] op, input logic [31:0] v1, input logic [31:0] v2,
                       input logic [31:0] vfs, input logic [7:0] sca, input logic [7:0] imm,
                       input logic [7:0] sh, input logic s_op, input logic [1:0] s_vec,
                       input logic [2:0] dest, input logic [4:0] cm, input logic [2:0] cw,
                       input logic s_int);
    valid_in     = 1'b1;
    opcode_in    = op;
    VEC1_in      = v1;
    VEC2_in      = v2;
    VFS_in       = vfs;
    sca1_in      = sca;
    inmediato_in = imm;
    shift_in     = sh;
    sel_op_in    = s_op;
    sel_vec_in   = s_vec;
    dir_dest_in  = dest;
    ctrl_mem_in  = cm;
    ctrl_wb_in   = cw;
    sel_int_in   = s_int;
  endtask

  task automatic go_idle();
    valid_in  = 1'b0;
    opcode_in = OP_NOP;
  endtask

  // scoreboard: compare retiring result against the head of exp_q
  task automatic expect_done(input string tag);
    logic [W-1:0] e;
    check({tag, "_valid"}, W'(valid_out), W'(1'b1));
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, W'(0), W'(1));
    end else begin
      e = exp_q.pop_front();
      check(tag, result_out, e);
      last_res = e;
    end
  endtask

  task automatic run_single(input string tag, input logic [3:0] op, input logic [31:0] v1,
                            input logic [31:0] v2, input logic [31:0] vfs, input logic [7:0] sca,
                            input logic [7:0] imm, input logic [7:0] sh, input logic s_op,
                            input logic [1:0] s_vec, input logic [31:0] exp);
    issue(op, v1, v2, vfs, sca, imm, sh, s_op, s_vec, 3'd1, CM_LOAD, CW_VEC, 1'b0);
    exp_q.push_back(exp);
    cycle();
    expect_done(tag);
    go_idle();
  endtask

  // Wait for a multi-cycle op to retire; upstream drops valid once stall falls.
  task automatic wait_multi();
    lat = 0;
    stall_cnt = 0;
    while (!valid_out && lat < 12) begin
      if (stall_out) stall_cnt++;
      else           valid_in = 1'b0;
      cycle();
      lat++;
    end
  endtask

  initial begin
    rst = 1'b1;
    issue(OP_ADD, '0, '0, '0, '0, '0, '0, 1'b0, SV_VEC2, '0, '0, '0, 1'b0);
    go_idle();
    #1;
    check("rst_result", result_out, '0);
    check("rst_valid", W'(valid_out), '0);
    check("rst_stall", W'(stall_out), '0);
    check("rst_ctrl", W'({ctrl_mem_out, ctrl_wb_out}), '0);
    repeat (2) cycle();
    rst = 1'b0;
    cycle();

    // ADD with full field check, then idle hold
    issue(OP_ADD, 32'h01020304, 32'h10FF0101, '0, '0, '0, '0, 1'b0, SV_VEC2,
          3'd5, CM_STORE, CW_VEC, 1'b1);
    exp_q.push_back(32'h11010405);
    cycle();
    expect_done("add");
    check("add_store", store_out, 32'h10FF0101);
    check("add_dest", W'(dir_dest_out), W'(3'd5));
    check("add_cmem", W'(ctrl_mem_out), W'(CM_STORE));
    check("add_cwb", W'(ctrl_wb_out), W'(CW_VEC));
    check("add_selint", W'(sel_int_out), W'(1'b1));
    go_idle();
    cycle();
    check("idle_valid", W'(valid_out), '0);
    check("idle_ctrl", W'({ctrl_mem_out, ctrl_wb_out}), '0);
    check("idle_hold", result_out, 32'h11010405);
    check("idle_dest_hold", W'(dir_dest_out), W'(3'd5));

    run_single("sub_imm", OP_SUB, 32'h00050A03, '0, '0, '0, 8'h05, '0, 1'b0, SV_IMM, 32'hFB0005FE);
    run_single("adds", OP_ADDS, 32'hF0F00101, 32'h20100101, '0, '0, '0, '0, 1'b0, SV_VEC2, 32'hFFFF0202);
    run_single("srl8", OP_SRL, 32'hFFFFFFFF, '0, '0, '0, '0, 8'd8, 1'b0, SV_VEC2, 32'h00000000);
    run_single("srl4", OP_SRL, 32'hF0801F01, '0, '0, '0, '0, 8'd4, 1'b0, SV_VEC2, 32'h0F080100);
    run_single("sll1", OP_SLL, 32'h81402001, '0, '0, '0, '0, 8'd1, 1'b0, SV_VEC2, 32'h02804002);
    run_single("and", OP_AND, 32'hF0F0F0F0, 32'h3C3C3C3C, '0, '0, '0, '0, 1'b0, SV_VEC2, 32'h30303030);
    run_single("or_vfs_sca", OP_OR, 32'h12345678, '0, 32'h0F000F00, 8'h30, '0, '0, 1'b1, SV_SCA, 32'h3F303F30);
    run_single("xor", OP_XOR, 32'hFF00FF00, 32'h0F0F0F0F, '0, '0, '0, '0, 1'b0, SV_VEC2, 32'hF00FF00F);
    run_single("min", OP_MIN, 32'h10FF0580, 32'h20011080, '0, '0, '0, '0, 1'b0, SV_VEC2, 32'h10010580);
    run_single("max", OP_MAX, 32'h10FF0580, 32'h20011080, '0, '0, '0, '0, 1'b0, SV_VEC2, 32'h20FF1080);
    run_single("mov_vfs", OP_MOV, 32'h11111111, '0, 32'hDEADBEEF, '0, '0, '0, 1'b0, SV_VFS, 32'hDEADBEEF);
    run_single("rsum", OP_RSUM, 32'h01020304, '0, '0, '0, '0, '0, 1'b0, SV_VEC2, 32'h0000000A);

    // MUL: broadcast scalar, serial lanes, stall and latency
    issue(OP_MUL, 32'h02030405, 32'h11223344, '0, 8'h03, '0, '0, 1'b0, SV_SCA,
          3'd6, CM_PC, CW_SCA, 1'b1);
    exp_q.push_back(32'h06090C0F);
    cycle();
    check("mul_state", W'(dbg_state), W'(ST_MUL));
    check("mul_no_early_valid", W'(valid_out), '0);
    wait_multi();
    check("mul_latency", W'(lat), W'(4));
    check("mul_stall_cycles", W'(stall_cnt), W'(3));
    expect_done("mul");
    check("mul_stall_low", W'(stall_out), '0);
    check("mul_store", store_out, 32'h11223344);
    check("mul_cmem", W'(ctrl_mem_out), W'(CM_PC));
    check("mul_cwb", W'(ctrl_wb_out), W'(CW_SCA));
    check("mul_dest", W'(dir_dest_out), W'(3'd6));
    cycle();
    check("mul_no_reexec_valid", W'(valid_out), '0);
    check("mul_no_reexec_state", W'(dbg_state), W'(ST_IDLE));

    // MAC with operands changed under stall; captured values must be used
    issue(OP_MAC, 32'h10203040, 32'h02020202, 32'h01010101, '0, '0, '0, 1'b0, SV_VEC2,
          3'd2, CM_LOAD, CW_VEC, 1'b0);
    exp_q.push_back(32'h21416181);
    cycle();
    VEC1_in = 32'hFFFFFFFF;
    VEC2_in = 32'h00000000;
    VFS_in  = 32'h55555555;
    wait_multi();
    check("mac_latency", W'(lat), W'(4));
    expect_done("mac");
    check("mac_store", store_out, 32'h02020202);
    go_idle();
    cycle();

    // Reset in the second MUL cycle aborts with no retire
    issue(OP_MUL, 32'h02030405, 32'h01010101, '0, 8'h03, '0, '0, 1'b0, SV_SCA,
          3'd7, CM_STORE, CW_VEC, 1'b1);
    cycle();
    cycle();
    check("abort_pre_state", W'(dbg_state), W'(ST_MUL));
    rst = 1'b1;
    #1;
    check("abort_result", result_out, '0);
    check("abort_store", store_out, '0);
    check("abort_valid", W'(valid_out), '0);
    check("abort_stall", W'(stall_out), '0);
    check("abort_state", W'(dbg_state), W'(ST_IDLE));
    go_idle();
    cycle();
    rst = 1'b0;
    lat = 0;
    repeat (5) begin
      cycle();
      if (valid_out) lat++;
    end
    check("abort_no_valid", W'(lat), '0);
    run_single("add_after_abort", OP_ADD, 32'h01020304, 32'h10FF0101, '0, '0, '0, '0, 1'b0,
               SV_VEC2, 32'h11010405);

    // Back-to-back ADD, RSUM, NOP with distinct control fields
    issue(OP_ADD, 32'h7F7F7F7F, 32'h01010101, '0, '0, '0, '0, 1'b0, SV_VEC2,
          3'd1, CM_STORE, CW_VEC, 1'b0);
    exp_q.push_back(32'h80808080);
    cycle();
    expect_done("b2b_add");
    check("b2b_add_cmem", W'(ctrl_mem_out), W'(CM_STORE));
    issue(OP_RSUM, 32'h80808080, '0, '0, '0, '0, '0, 1'b0, SV_VEC2,
          3'd2, CM_LOAD, CW_SCA, 1'b1);
    exp_q.push_back(32'h00000000);
    cycle();
    expect_done("b2b_rsum");
    check("b2b_rsum_cmem", W'(ctrl_mem_out), W'(CM_LOAD));
    check("b2b_rsum_cwb", W'(ctrl_wb_out), W'(CW_SCA));
    issue(OP_NOP, 32'hCAFEBABE, 32'h12345678, '0, '0, '0, '0, 1'b0, SV_VEC2,
          3'd3, CM_PC, CW_VEC, 1'b0);
    exp_q.push_back(32'hCAFEBABE);
    cycle();
    expect_done("b2b_nop");
    check("b2b_nop_cmem", W'(ctrl_mem_out), W'(CM_PC));
    check("b2b_nop_dest", W'(dir_dest_out), W'(3'd3));
    go_idle();
    cycle();
    check("b2b_end_valid", W'(valid_out), '0);
    check("b2b_end_ctrl", W'({ctrl_mem_out, ctrl_wb_out}), '0);
    check("queue_empty", W'(exp_q.size()), '0);

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
